// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing 32-bit words into instruction memory
module imem_loader #(
   parameter int DW    = 32,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   load_len,
   input  logic          abort,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [1:0]    byte_cnt;
   logic [AW-1:0] word_cnt;
   logic [AW:0]   len_q;
   logic [DW-1:0] asm_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          err_q;
   logic          len_ok;
   logic          last_word;

   assign len_ok    = (load_len != '0) && (load_len <= (AW+1)'(DEPTH));
   assign last_word = ({1'b0, word_cnt} == (len_q - (AW+1)'(1)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start && len_ok) begin
               state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            // abort beats a simultaneous final byte: the partial word is dropped
            if (abort) begin
               state_nx = S_IDLE;
            end else if (byte_valid && (byte_cnt == 2'd3)) begin
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else if (last_word) begin
               state_nx = S_DONE;
            end else begin
               state_nx = S_LOAD;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         word_cnt <= '0;
         len_q    <= '0;
         asm_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     len_q    <= load_len;
                     byte_cnt <= '0;
                     word_cnt <= '0;
                     asm_q    <= '0;
                     err_q    <= 1'b0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (abort) begin
                  err_q    <= 1'b1;
                  byte_cnt <= '0;
                  asm_q    <= '0;
               end else if (byte_valid) begin
                  asm_q[{byte_cnt, 3'b000} +: 8] <= byte_data;
                  byte_cnt                       <= byte_cnt + 2'd1;
                  // output registers are loaded here so they hold outside WRITE
                  if (byte_cnt == 2'd3) begin
                     addr_q  <= word_cnt;
                     wdata_q <= {byte_data, asm_q[DW-9:0]};
                  end
               end
            end
            S_WRITE: begin
               if (abort) begin
                  err_q <= 1'b1;
               end else if (!last_word) begin
                  word_cnt <= word_cnt + AW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign byte_ready = (state == S_LOAD);
   assign mem_we     = (state == S_WRITE);
   assign busy       = (state == S_LOAD) || (state == S_WRITE);
   assign done       = (state == S_DONE);
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [6:0]  load_len;
   logic        abort;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int done_cnt = 0;
   int dbl_we  = 0;
   logic prev_we = 1'b0;
   logic [5:0]  wa[$];
   logic [31:0] wd[$];
   int          wc[$];

   imem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .load_len   (load_len),
      .abort      (abort),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
         wc.push_back(cyc);
      end
      if (mem_we && prev_we) dbl_we = dbl_we + 1;
      if (done) done_cnt = done_cnt + 1;
      prev_we = mem_we;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, observed running required finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("byte_ready_timeout", 64'(byte_ready), 64'd1);
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
         if (gap) tick();
      end
   endtask

   task automatic do_start(input logic [6:0] len);
      start    = 1'b1;
      load_len = len;
      tick();
      start    = 1'b0;
   endtask

   initial begin
      int c0;
      int bad;
      int nw;
      rst_n = 1'b0; start = 1'b0; load_len = '0; abort = 1'b0;
      byte_valid = 1'b0; byte_data = '0;
      tick(); tick();

      // reset state
      chk("rst_byte_ready", 64'(byte_ready), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      tick();

      // basic two-word load, back-to-back bytes
      do_start(7'd2);
      chk("basic_busy", 64'(busy), 64'd1);
      chk("basic_ready", 64'(byte_ready), 64'd1);
      send_word(32'h00100513, 1'b0);
      chk("basic_we0", 64'(mem_we), 64'd1);
      chk("basic_addr0", 64'(mem_addr), 64'd0);
      chk("basic_data0", 64'(mem_wdata), 64'h00100513);
      chk("basic_ready_wr", 64'(byte_ready), 64'd0);
      send_word(32'h00158593, 1'b0);
      chk("basic_we1", 64'(mem_we), 64'd1);
      chk("basic_addr1", 64'(mem_addr), 64'd1);
      chk("basic_data1", 64'(mem_wdata), 64'h00158593);
      tick();
      chk("basic_done", 64'(done), 64'd1);
      chk("basic_busy_done", 64'(busy), 64'd0);
      tick();
      chk("basic_done_pulse", 64'(done), 64'd0);
      chk("basic_err", 64'(err), 64'd0);
      chk("basic_nwrites", 64'(wa.size()), 64'd2);
      chk("basic_addr_hold", 64'(mem_addr), 64'd1);
      chk("basic_data_hold", 64'(mem_wdata), 64'h00158593);

      // stalled stream: byte_valid 1,0,1,0
      wa.delete(); wd.delete(); wc.delete();
      do_start(7'd2);
      send_word(32'h00100513, 1'b1);
      send_word(32'h00158593, 1'b1);
      tick(); tick();
      chk("stall_nwrites", 64'(wa.size()), 64'd2);
      if (wa.size() == 2) begin
         chk("stall_addr0", 64'(wa[0]), 64'd0);
         chk("stall_data0", 64'(wd[0]), 64'h00100513);
         chk("stall_addr1", 64'(wa[1]), 64'd1);
         chk("stall_data1", 64'(wd[1]), 64'h00158593);
      end

      // full depth
      wa.delete(); wd.delete(); wc.delete();
      done_cnt = 0;
      do_start(7'd64);
      c0 = cyc;
      for (int k = 0; k < 64; k++) send_word(32'hA5000000 + 32'(k), 1'b0);
      for (int k = 0; k < 10; k++) tick();
      chk("full_nwrites", 64'(wa.size()), 64'd64);
      bad = 0;
      if (wa.size() == 64) begin
         for (int k = 0; k < 64; k++)
            if (wa[k] !== 6'(k) || wd[k] !== 32'hA5000000 + 32'(k)) bad++;
         chk("full_first_cycle", 64'(wc[0] - c0), 64'd4);
         chk("full_last_cycle", 64'(wc[63] - c0), 64'd319);
      end
      chk("full_data_errors", 64'(bad), 64'd0);
      chk("full_done_count", 64'(done_cnt), 64'd1);
      chk("full_no_double_we", 64'(dbl_we), 64'd0);

      // illegal lengths
      wa.delete(); wd.delete(); wc.delete();
      do_start(7'd0);
      chk("len0_err", 64'(err), 64'd1);
      chk("len0_busy", 64'(busy), 64'd0);
      chk("len0_ready", 64'(byte_ready), 64'd0);
      tick();
      do_start(7'd65);
      chk("len65_err", 64'(err), 64'd1);
      chk("len65_busy", 64'(busy), 64'd0);
      byte_valid = 1'b1;
      tick(); tick();
      chk("len65_ready", 64'(byte_ready), 64'd0);
      byte_valid = 1'b0;
      chk("illegal_no_we", 64'(wa.size()), 64'd0);
      do_start(7'd1);
      chk("legal_clears_err", 64'(err), 64'd0);
      chk("legal_busy", 64'(busy), 64'd1);
      send_word(32'h44332211, 1'b0);
      chk("legal_data", 64'(mem_wdata), 64'h44332211);
      tick(); tick();

      // abort after 6 bytes of a 4-word load
      wa.delete(); wd.delete(); wc.delete();
      done_cnt = 0;
      do_start(7'd4);
      send_word(32'hDEADBEEF, 1'b0);
      send_byte(8'h01);
      send_byte(8'h02);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_err", 64'(err), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      for (int k = 0; k < 4; k++) tick();
      chk("abort_nwrites", 64'(wa.size()), 64'd1);
      if (wa.size() == 1) chk("abort_addr", 64'(wa[0]), 64'd0);
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      // start and abort together in IDLE: start wins
      abort = 1'b1;
      do_start(7'd1);
      abort = 1'b0;
      chk("restart_busy", 64'(busy), 64'd1);
      chk("restart_err", 64'(err), 64'd0);
      send_word(32'hCAFEF00D, 1'b0);
      chk("restart_addr", 64'(mem_addr), 64'd0);
      chk("restart_data", 64'(mem_wdata), 64'hCAFEF00D);
      tick();
      chk("restart_done", 64'(done), 64'd1);
      tick();

      // reset mid-load
      do_start(7'd2);
      send_word(32'h12345678, 1'b0);
      send_byte(8'hAA);
      send_byte(8'hBB);
      nw = wa.size();
      rst_n = 1'b0;
      tick();
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_ready", 64'(byte_ready), 64'd0);
      chk("mrst_addr", 64'(mem_addr), 64'd0);
      chk("mrst_data", 64'(mem_wdata), 64'd0);
      chk("mrst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      byte_valid = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      byte_valid = 1'b0;
      chk("mrst_no_we", 64'(wa.size() - nw), 64'd0);
      chk("mrst_idle_ready", 64'(byte_ready), 64'd0);
      chk("final_no_double_we", 64'(dbl_we), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write side of the 64x32 instruction memory.
- Accepts a byte stream from a host/boot link over a valid/ready handshake.
- Assembles the bytes little-endian into 32-bit instruction words.
- Issues single-cycle word writes (we/addr/wdata) into instruction memory starting at word 0.
- Core reset is held externally until the loader reports done.

Parameters:
- DW, 32, instruction word width (fixed at 4 bytes; other values unsupported).
- DEPTH, 64, instruction memory depth in words.
- AW, 6, word address width, equal to log2(DEPTH).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- load_len  input  AW+1  number of words to load; sampled with start; legal range 1..DEPTH.
- abort  input  1  cancel an in-progress load.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  AW  word write address.
- mem_wdata  output  DW  word write data.
- busy  output  1  high in LOAD and WRITE.
- done  output  1  one-cycle pulse when the final word has been written.
- err  output  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; byte_cnt=0, word_cnt=0, asm=0, len_q=0.
  - All outputs 0; err=0.
  - Reset mid-load discards the partial word; no further writes occur.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - byte_ready=0.
  - start=1 with 1<=load_len<=DEPTH: latch len_q, clear byte_cnt/word_cnt/asm/err, go to LOAD.
  - start=1 with load_len=0 or load_len>DEPTH: err=1, stay in IDLE.
- LOAD:
  - byte_ready=1.
  - A byte transfers when byte_valid and byte_ready are both 1.
  - Each transfer writes byte_data into asm[8*byte_cnt+7 : 8*byte_cnt], so the first byte is bits 7:0; byte_cnt then increments mod 4.
  - On the transfer with byte_cnt==3, go to WRITE next cycle.
  - byte_valid=0 simply stalls; there is no timeout.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_addr=word_cnt[AW-1:0], mem_wdata=asm.
  - byte_ready=0.
  - If word_cnt==len_q-1, go to DONE; otherwise word_cnt++ and return to LOAD.
- DONE (1 cycle): done=1, byte_ready=0, then IDLE.
- Output timing:
  - mem_we, busy, done and byte_ready are pure state decodes.
  - mem_addr and mem_wdata are driven from registers and hold their last values outside WRITE.
- Throughput: 5 cycles per word minimum (4 byte transfers + 1 write cycle).
- abort:
  - Honoured in LOAD: next state IDLE, err=1, partial word discarded, no write.
  - In WRITE, the write completes that cycle, then the FSM goes to IDLE with err=1 instead of LOAD/DONE.
  - Ignored in IDLE and DONE.
- start while busy or in DONE is ignored and does not affect load_len capture.
- abort and start in the same IDLE cycle: start wins.
- Full depth: load_len=DEPTH writes addresses 0..DEPTH-1; word_cnt never wraps.
- No write is ever issued outside WRITE; mem_we is never high for two consecutive cycles.

Test Plan:
- Basic load: start, load_len=2; bytes 0x13,0x05,0x10,0x00,0x93,0x85,0x15,0x00 streamed back-to-back → mem_we pulses twice: addr 0 data 0x00100513, then addr 1 data 0x00158593. done pulses 1 cycle after the second write; busy falls with done; err=0.
- Backpressure/stall: same stream with byte_valid toggled 1,0,1,0 → identical writes; byte_ready=0 during WRITE and any byte offered then is not consumed; written values unchanged.
- Full depth: load_len=64, word k = 0xA5000000+k → 64 writes to addr 0..63 with matching data; first write at cycle 5 after LOAD entry, last at cycle 320; done once; no 65th write.
- Illegal length: start with load_len=0, then with load_len=65 → err=1, busy=0, byte_ready stays 0, no mem_we. A subsequent legal start clears err.
- Abort: load_len=4, abort after 6 bytes → exactly one write (addr 0), then IDLE, err=1, done never asserted. A new start with load_len=1 writes addr 0 again.
- Reset mid-load: rst_n=0 after 2 bytes of word 1 → next cycle all outputs 0 and state IDLE; no further mem_we until a new start.
